// File: rtl/timer_apb_seq.sv
// APB-master sequencer that programs timer_top for one run command, counts
// OVF/URF events (clearing TSR after each) and disables the timer on completion or stop.
module timer_apb_seq #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] TDR_A      = 'h00,
    parameter logic [ADDR_WIDTH-1:0] TCR_A      = 'h01,
    parameter logic [ADDR_WIDTH-1:0] TSR_A      = 'h02,
    parameter int                    MAX_WAIT   = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [7:0]            cmd_reload,
    input  logic [1:0]            cmd_cks,
    input  logic                  cmd_down,
    input  logic [7:0]            cmd_periods,
    input  logic                  stop,
    output logic                  m_psel,
    output logic                  m_penable,
    output logic                  m_pwrite,
    output logic [ADDR_WIDTH-1:0] m_paddr,
    output logic [DATA_WIDTH-1:0] m_pwdata,
    input  logic                  m_pready,
    input  logic                  m_pslverr,
    input  logic                  TMR_OVF,
    input  logic                  TMR_URF,
    output logic                  busy,
    output logic [7:0]            event_cnt,
    output logic                  done,
    output logic                  err,
    output logic                  overrun
);

    // state   | meaning
    // IDLE    | waiting for a run command
    // WR_TDR  | writing reload value to TDR
    // WR_LOAD | TCR write with load bit set
    // WR_RUN  | TCR write with enable and direction
    // RUN     | timer running, watching for events or stop
    // WR_CLR  | clearing TSR after an event
    // WR_STOP | TCR write disabling the timer
    // DONE    | one-cycle completion pulse
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_TDR  = 3'd1;
    localparam logic [2:0] S_WR_LOAD = 3'd2;
    localparam logic [2:0] S_WR_RUN  = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;
    localparam logic [2:0] S_WR_CLR  = 3'd5;
    localparam logic [2:0] S_WR_STOP = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [2:0]    state;
    logic [2:0]    wr_next;
    logic          acc;
    logic [WW-1:0] wait_cnt;
    logic [7:0]    reload_q;
    logic [1:0]    cks_q;
    logic          down_q;
    logic [7:0]    periods_q;
    logic          pending;
    logic          src;
    logic          src_q;
    logic          rise;
    logic          accept;
    logic          enter_clr;
    logic          is_wr;
    logic [7:0]    cnt_inc;

    assign is_wr     = (state == S_WR_TDR) || (state == S_WR_LOAD) || (state == S_WR_RUN) ||
                       (state == S_WR_CLR) || (state == S_WR_STOP);
    assign busy      = (state != S_IDLE);
    assign cmd_ready = (state == S_IDLE);
    assign done      = (state == S_DONE);
    assign m_psel    = is_wr;
    assign m_pwrite  = is_wr;
    assign m_penable = acc;

    assign src       = down_q ? TMR_URF : TMR_OVF;
    assign rise      = src & ~src_q;
    assign accept    = cmd_valid & cmd_ready;
    assign enter_clr = (state == S_RUN) && !stop && pending;
    assign cnt_inc   = event_cnt + 8'd1;

    always_comb begin
        wr_next = S_IDLE;
        case (state)
            S_WR_TDR:  wr_next = S_WR_LOAD;
            S_WR_LOAD: wr_next = S_WR_RUN;
            S_WR_RUN:  wr_next = S_RUN;
            S_WR_CLR:  wr_next = ((periods_q != 8'd0) && (cnt_inc == periods_q)) ? S_WR_STOP : S_RUN;
            S_WR_STOP: wr_next = S_DONE;
            default:   wr_next = S_IDLE;
        endcase
    end

    // address/data derive from registered command fields, so they hold for the whole transfer
    always_comb begin
        m_paddr  = '0;
        m_pwdata = '0;
        case (state)
            S_WR_TDR: begin
                m_paddr  = TDR_A;
                m_pwdata = reload_q;
            end
            S_WR_LOAD: begin
                m_paddr  = TCR_A;
                m_pwdata = {6'b100000, cks_q};
            end
            S_WR_RUN: begin
                m_paddr  = TCR_A;
                m_pwdata = {2'b00, down_q, 3'b100, cks_q};
            end
            S_WR_CLR: begin
                m_paddr  = TSR_A;
                m_pwdata = 8'h00;
            end
            S_WR_STOP: begin
                m_paddr  = TCR_A;
                m_pwdata = {6'b000000, cks_q};
            end
            default: begin
                m_paddr  = '0;
                m_pwdata = '0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            state     <= S_IDLE;
            acc       <= 1'b0;
            wait_cnt  <= '0;
            reload_q  <= 8'd0;
            cks_q     <= 2'd0;
            down_q    <= 1'b0;
            periods_q <= 8'd0;
            event_cnt <= 8'd0;
            err       <= 1'b0;
            overrun   <= 1'b0;
            pending   <= 1'b0;
            src_q     <= 1'b0;
        end else begin
            err   <= 1'b0;
            src_q <= src;

            // a new edge beats the clear when both land in the same cycle
            if (busy && rise)
                pending <= 1'b1;
            else if (enter_clr || accept)
                pending <= 1'b0;

            if (accept)
                overrun <= 1'b0;
            else if (busy && rise && pending)
                overrun <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        reload_q  <= cmd_reload;
                        cks_q     <= cmd_cks;
                        down_q    <= cmd_down;
                        periods_q <= cmd_periods;
                        event_cnt <= 8'd0;
                        state     <= S_WR_TDR;
                    end
                end
                S_RUN: begin
                    if (stop)
                        state <= S_WR_STOP;
                    else if (pending)
                        state <= S_WR_CLR;
                end
                S_DONE: state <= S_IDLE;
                default: begin
                    if (!acc) begin
                        acc      <= 1'b1;
                        wait_cnt <= WW'(MAX_WAIT);
                    end else if (m_pready) begin
                        acc <= 1'b0;
                        if (m_pslverr) begin
                            err   <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            state <= wr_next;
                            if (state == S_WR_CLR)
                                event_cnt <= cnt_inc;
                        end
                    end else if (wait_cnt <= WW'(1)) begin
                        acc   <= 1'b0;
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_apb_seq.sv
// Bench for timer_apb_seq: APB slave model with wait/error injection, sticky timer
// flags, and an expected write-sequence model built from each run's command.
module tb_timer_apb_seq;

    localparam logic [7:0] TDR_A = 8'h00;
    localparam logic [7:0] TCR_A = 8'h01;
    localparam logic [7:0] TSR_A = 8'h02;

    logic       PCLK = 1'b0;
    logic       PRESET_n;
    logic       cmd_valid, cmd_ready, cmd_down, stop;
    logic [7:0] cmd_reload, cmd_periods;
    logic [1:0] cmd_cks;
    logic       m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
    logic [7:0] m_paddr, m_pwdata;
    logic       tmr_ovf, tmr_urf;
    logic       busy, done, err, overrun;
    logic [7:0] event_cnt;

    int n_vec = 0;
    int n_mis = 0;

    // slave model state
    logic [7:0] log_a[$];
    logic [7:0] log_d[$];
    int         log_w[$];
    bit         log_s[$];
    int         clr_count = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         wait_idx = -1;
    int         wait_n = 0;
    int         err_idx = -1;
    int         acc_cnt = 0;
    int         cur_waits = 0;
    bit         cur_err = 0;
    bit         cur_stable = 1;
    logic [7:0] setup_a, setup_d;
    logic [15:0] exp_q[$];

    timer_apb_seq #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8),
        .TDR_A(TDR_A), .TCR_A(TCR_A), .TSR_A(TSR_A), .MAX_WAIT(16)
    ) dut (
        .PCLK(PCLK), .PRESET_n(PRESET_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_reload(cmd_reload),
        .cmd_cks(cmd_cks), .cmd_down(cmd_down), .cmd_periods(cmd_periods), .stop(stop),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata),
        .m_pready(m_pready), .m_pslverr(m_pslverr),
        .TMR_OVF(tmr_ovf), .TMR_URF(tmr_urf),
        .busy(busy), .event_cnt(event_cnt), .done(done), .err(err), .overrun(overrun)
    );

    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (m_psel && !m_penable) begin
            setup_a    = m_paddr;
            setup_d    = m_pwdata;
            acc_cnt    = 0;
            cur_stable = 1;
            cur_waits  = (log_a.size() == wait_idx) ? wait_n : 0;
            cur_err    = (log_a.size() == err_idx);
            m_pready   = 1'b0;
            m_pslverr  = 1'b0;
        end else if (m_psel && m_penable) begin
            if (m_paddr !== setup_a || m_pwdata !== setup_d || m_pwrite !== 1'b1) cur_stable = 0;
            m_pready  = (acc_cnt >= cur_waits);
            m_pslverr = m_pready && cur_err;
            acc_cnt++;
        end else begin
            m_pready  = 1'b0;
            m_pslverr = 1'b0;
        end
    end

    always @(posedge PCLK) begin
        if (PRESET_n && m_psel && m_penable && m_pready) begin
            log_a.push_back(m_paddr);
            log_d.push_back(m_pwdata);
            log_w.push_back(acc_cnt);
            log_s.push_back(cur_stable);
            if (m_paddr == TSR_A && !m_pslverr) clr_count++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic build_exp(input logic [7:0] reload, input logic [1:0] cks,
                             input logic down, input int nev);
        exp_q.delete();
        exp_q.push_back({TDR_A, reload});
        exp_q.push_back({TCR_A, 8'h80 + 8'(cks)});
        exp_q.push_back({TCR_A, 8'h10 + (down ? 8'h20 : 8'h00) + 8'(cks)});
        for (int i = 0; i < nev; i++) exp_q.push_back({TSR_A, 8'h00});
        exp_q.push_back({TCR_A, 8'(cks)});
    endtask

    task automatic wait_log(input int n, input string tag);
        int k = 0;
        while (log_a.size() < n && k < 500) begin
            @(negedge PCLK);
            k++;
        end
        check(tag, (log_a.size() >= n), 1);
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!cmd_ready && k < 100) begin
            @(negedge PCLK);
            k++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
    endtask

    task automatic start_cmd(input logic [7:0] reload, input logic [1:0] cks,
                             input logic down, input logic [7:0] periods);
        @(negedge PCLK);
        wait_ready();
        cmd_reload  = reload;
        cmd_cks     = cks;
        cmd_down    = down;
        cmd_periods = periods;
        cmd_valid   = 1'b1;
        @(negedge PCLK);
        cmd_valid   = 1'b0;
    endtask

    task automatic do_event(input logic down);
        int c0, k;
        c0 = clr_count;
        k  = 0;
        @(negedge PCLK);
        if (down) tmr_urf = 1'b1; else tmr_ovf = 1'b1;
        @(negedge PCLK);
        check("no_bus_while_pending", m_psel, 0);
        @(negedge PCLK);
        check("clr_setup", {m_psel, m_penable, m_paddr}, {1'b1, 1'b0, TSR_A});
        while (clr_count == c0 && k < 100) begin
            @(negedge PCLK);
            k++;
        end
        check("clr_seen", clr_count - c0, 1);
        @(negedge PCLK);
        tmr_ovf = 1'b0;
        tmr_urf = 1'b0;
    endtask

    task automatic run_full(input logic [7:0] reload, input logic [1:0] cks, input logic down,
                            input logic [7:0] periods, input int nev, input int gap);
        int base, d0, e0;
        base = log_a.size();
        d0   = done_cnt;
        e0   = err_cnt;
        build_exp(reload, cks, down, nev);
        start_cmd(reload, cks, down, periods);
        wait_log(base + 3, "run_reached");
        for (int i = 0; i < nev; i++) begin
            repeat (gap) @(negedge PCLK);
            do_event(down);
        end
        if (periods == 8'd0) begin
            @(negedge PCLK);
            stop = 1'b1;
        end
        wait_log(base + exp_q.size(), "stop_write");
        check("done_pulse", {done, cmd_ready}, 2'b10);
        @(negedge PCLK);
        stop = 1'b0;
        check("ready_after_done", {done, cmd_ready}, 2'b01);
        check("write_count", log_a.size(), base + exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < log_a.size(); i++) begin
            check("write", {log_a[base+i], log_d[base+i]}, exp_q[i]);
            check("stable", log_s[base+i], 1);
        end
        check("event_cnt", event_cnt, nev % 256);
        check("done_count", done_cnt - d0, 1);
        check("err_count", err_cnt - e0, 0);
        check("overrun_clear", overrun, 0);
    endtask

    initial begin
        int base, e0, d0, k;
        PRESET_n = 1'b0;
        cmd_valid = 1'b0; cmd_reload = 8'h00; cmd_cks = 2'd0; cmd_down = 1'b0;
        cmd_periods = 8'd0; stop = 1'b0; tmr_ovf = 1'b0; tmr_urf = 1'b0;
        m_pready = 1'b0; m_pslverr = 1'b0;
        #12;
        check("reset_outputs", {cmd_ready, busy, done, err, overrun, m_psel, m_penable, m_pwrite},
              8'b1000_0000);
        check("reset_cnt", event_cnt, 0);
        @(negedge PCLK);
        PRESET_n = 1'b1;

        // basic single-period run
        run_full(8'hFF, 2'd0, 1'b0, 8'd1, 1, 5);
        // count-down, three periods
        run_full(8'h00, 2'd3, 1'b1, 8'd3, 3, 20);
        // free-running until stop
        run_full(8'h5A, 2'($urandom_range(0, 3)), 1'b0, 8'd0, 4, 6);

        // three wait states on the TDR write
        base = log_a.size();
        wait_idx = base; wait_n = 3;
        run_full(8'hC3, 2'd1, 1'b0, 8'd1, 1, 4);
        check("tdr_access_cycles", log_w[base], 4);
        wait_idx = -1; wait_n = 0;

        // PSLVERR on the load write
        base = log_a.size(); e0 = err_cnt; d0 = done_cnt;
        err_idx = base + 1;
        start_cmd(8'h11, 2'd2, 1'b0, 8'd2);
        wait_log(base + 2, "err_write");
        check("err_pulse_ready", {err, cmd_ready, m_psel}, 3'b110);
        repeat (10) @(negedge PCLK);
        check("no_writes_after_err", log_a.size(), base + 2);
        check("err_count_slverr", err_cnt - e0, 1);
        check("no_done_on_err", done_cnt - d0, 0);
        err_idx = -1;

        // access timeout
        base = log_a.size(); e0 = err_cnt;
        wait_idx = base; wait_n = 1000;
        start_cmd(8'h22, 2'd0, 1'b0, 8'd1);
        k = 0;
        while (err_cnt == e0 && k < 60) begin
            @(negedge PCLK);
            k++;
        end
        check("timeout_err", err_cnt - e0, 1);
        check("timeout_cycles", k, 18);
        check("timeout_idle", {cmd_ready, m_psel, m_penable}, 3'b100);
        check("timeout_no_write", log_a.size(), base);
        wait_idx = -1; wait_n = 0;

        // overrun: two edges while the WR_RUN access is stretched
        base = log_a.size();
        wait_idx = base + 2; wait_n = 8;
        start_cmd(8'h33, 2'd0, 1'b0, 8'd1);
        wait_log(base + 2, "ovr_run_write");
        tmr_ovf = 1'b1;
        @(negedge PCLK); tmr_ovf = 1'b0;
        @(negedge PCLK); tmr_ovf = 1'b1;
        wait_log(base + 5, "ovr_stop");
        tmr_ovf = 1'b0;
        wait_ready();
        check("overrun_set", overrun, 1);
        check("overrun_event_cnt", event_cnt, 1);
        wait_idx = -1; wait_n = 0;

        // async reset during WR_RUN access
        base = log_a.size();
        start_cmd(8'h44, 2'd1, 1'b0, 8'd1);
        wait_log(base + 2, "rst_run_write");
        k = 0;
        while (!m_penable && k < 10) begin
            @(negedge PCLK);
            k++;
        end
        #1 PRESET_n = 1'b0;
        #1 check("async_reset", {m_psel, m_penable, busy, cmd_ready}, 4'b0001);
        @(negedge PCLK);
        PRESET_n = 1'b1;
        run_full(8'h77, 2'd2, 1'b1, 8'd2, 2, 3);

        // randomized runs
        for (int r = 0; r < 6; r++) begin
            logic [7:0] rl, pr;
            logic [1:0] ck;
            logic       dn;
            int         nev;
            rl  = 8'($urandom);
            ck  = 2'($urandom_range(0, 3));
            dn  = 1'($urandom_range(0, 1));
            pr  = (r % 3 == 0) ? 8'd0 : 8'($urandom_range(1, 3));
            nev = (pr == 8'd0) ? $urandom_range(1, 3) : int'(pr);
            wait_idx = log_a.size() + $urandom_range(0, 2);
            wait_n   = $urandom_range(0, 4);
            run_full(rl, ck, dn, pr, nev, $urandom_range(2, 15));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
